// File: rtl/ifetch_rvc.sv
// ifetch_rvc: instruction fetch with a halfword queue that reassembles 16/32-bit RISC-V instructions.
// Define IFU_BYPASS_EN to let an ack into an empty queue feed decode in the same cycle.
module ifetch_rvc #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        branch_flush_i,
  input  logic [63:0] branch_target_i,
  input  logic        load_use_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        is_compressed_o,
  output logic        valid_o
);
  localparam int            PW  = $clog2(QDEPTH);
  localparam int            CW  = PW + 1;
  localparam logic [31:0]   NOP = 32'h0000_0013;
  localparam logic [CW-1:0] QD  = CW'(QDEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
  logic          req_q, req_d;
  logic [63:0]   addr_q, addr_d;
  logic [31:0]   inst_q, inst_d;
  logic [63:0]   pc_q, pc_d;
  logic          comp_q, comp_d, valid_q, valid_d;

  logic          ack_run_s, byp_s, deq_en_s;
  logic [1:0]    inc_n_s, pop_s, q_pop_s, push_n_s;
  logic [15:0]   inc_hw0_s, inc_hw1_s, push_hw0_s, v0_s, v1_s;
  logic [CW-1:0] avail_s;

  // Incoming halfwords, dequeue selection and queue pointer update
  always_comb begin
    ack_run_s = imem_ack_i && req_q && (state_q == RUN) && !branch_flush_i;
    inc_hw0_s = imem_rdata_i[15:0];
    inc_hw1_s = imem_rdata_i[31:16];
    if (ack_run_s) begin
      if (fetch_pc_q[1]) begin
        inc_n_s   = 2'd1;
        inc_hw0_s = imem_rdata_i[31:16];
      end else begin
        inc_n_s = 2'd2;
      end
    end else begin
      inc_n_s = 2'd0;
    end
`ifdef IFU_BYPASS_EN
    byp_s = ack_run_s && (count_q == {CW{1'b0}}) && !load_use_i;
`else
    byp_s = 1'b0;
`endif
    // The dequeue logic looks at the first two halfwords of whichever source is active
    if (byp_s) begin
      v0_s    = inc_hw0_s;
      v1_s    = inc_hw1_s;
      avail_s = CW'(inc_n_s);
    end else begin
      v0_s    = mem_q[head_q];
      v1_s    = mem_q[head_q + PW'(1'b1)];
      avail_s = count_q;
    end
    deq_en_s = !load_use_i && !branch_flush_i;
    if (deq_en_s && (v0_s[1:0] != 2'b11) && (avail_s >= CW'(1'b1))) begin
      pop_s = 2'd1;
    end else if (deq_en_s && (v0_s[1:0] == 2'b11) && (avail_s >= CW'(2'd2))) begin
      pop_s = 2'd2;
    end else begin
      pop_s = 2'd0;
    end
    q_pop_s    = byp_s ? 2'd0 : pop_s;
    push_n_s   = byp_s ? (inc_n_s - pop_s) : inc_n_s;
    push_hw0_s = (byp_s && (pop_s == 2'd1)) ? inc_hw1_s : inc_hw0_s;
    if (branch_flush_i) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      head_d  = head_q + PW'(q_pop_s);
      tail_d  = tail_q + PW'(push_n_s);
      count_d = count_q - CW'(q_pop_s) + CW'(push_n_s);
    end
  end

  // IF/ID register next state and head PC advance
  always_comb begin
    inst_d    = inst_q;
    pc_d      = pc_q;
    comp_d    = comp_q;
    valid_d   = valid_q;
    head_pc_d = head_pc_q;
    if (branch_flush_i) begin
      inst_d    = NOP;
      comp_d    = 1'b0;
      valid_d   = 1'b0;
      head_pc_d = branch_target_i & ~64'h1;
    end else if (load_use_i) begin
      valid_d = valid_q;
    end else if (pop_s == 2'd1) begin
      inst_d    = {16'h0000, v0_s};
      pc_d      = head_pc_q;
      comp_d    = 1'b1;
      valid_d   = 1'b1;
      head_pc_d = head_pc_q + 64'h2;
    end else if (pop_s == 2'd2) begin
      inst_d    = {v1_s, v0_s};
      pc_d      = head_pc_q;
      comp_d    = 1'b0;
      valid_d   = 1'b1;
      head_pc_d = head_pc_q + 64'h4;
    end else begin
      inst_d  = NOP;
      comp_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  // Fetch FSM: request issue, ack completion and post-flush drain
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      RUN: begin
        if (branch_flush_i) begin
          fetch_pc_d = branch_target_i & ~64'h1;
          if (req_q && !imem_ack_i) begin
            state_d = DRAIN;
          end else begin
            req_d = 1'b0;
          end
        end else if (req_q) begin
          if (imem_ack_i) begin
            req_d      = 1'b0;
            fetch_pc_d = (fetch_pc_q & ~64'h3) + 64'h4;
          end else begin
            req_d = 1'b1;
          end
        end else if ((QD - count_q) >= CW'(2'd2)) begin
          req_d  = 1'b1;
          addr_d = fetch_pc_q & ~64'h3;
        end else begin
          req_d = 1'b0;
        end
      end
      DRAIN: begin
        if (branch_flush_i) begin
          fetch_pc_d = branch_target_i & ~64'h1;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = RUN;
        end else begin
          req_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        req_d   = 1'b0;
      end
    endcase
  end

  // Halfword queue storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= 16'h0000;
    end else if (!branch_flush_i) begin
      if (push_n_s != 2'd0) mem_q[tail_q] <= push_hw0_s;
      if (push_n_s == 2'd2) mem_q[tail_q + PW'(1'b1)] <= inc_hw1_s;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC & ~64'h3;
      inst_q     <= NOP;
      pc_q       <= RESET_PC;
      comp_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      comp_q     <= comp_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req_o      = req_q;
  assign imem_addr_o     = addr_q;
  assign inst_o          = inst_q;
  assign pc_o            = pc_q;
  assign is_compressed_o = comp_q;
  assign valid_o         = valid_q;
endmodule

// File: tb/tb_ifetch_rvc.sv
// Directed bench for ifetch_rvc: a per-cycle vector table plus hand-written flush/drain/reset sequences.
module tb_ifetch_rvc;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] B   = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        branch_flush_i = 1'b0;
  logic [63:0] branch_target_i = 64'h0;
  logic        load_use_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        is_compressed_o;
  logic        valid_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        flush;
    logic [63:0] tgt;
    logic        lu;
    logic        e_req;
    logic [63:0] e_addr;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_comp;
    logic        e_valid;
  } vec_t;

  vec_t vq[$];

  ifetch_rvc #(.RESET_PC(64'h8000_0000), .QDEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .branch_flush_i(branch_flush_i), .branch_target_i(branch_target_i),
    .load_use_i(load_use_i),
    .inst_o(inst_o), .pc_o(pc_o), .is_compressed_o(is_compressed_o), .valid_o(valid_o)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic ack, input logic [31:0] rd, input logic fl,
                              input logic [63:0] tg, input logic lu, input logic er,
                              input logic [63:0] ea, input logic [31:0] ei,
                              input logic [63:0] ep, input logic ec, input logic ev);
    vec_t v;
    v.ack = ack; v.rdata = rd; v.flush = fl; v.tgt = tg; v.lu = lu;
    v.e_req = er; v.e_addr = ea; v.e_inst = ei; v.e_pc = ep; v.e_comp = ec; v.e_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic er, input logic [63:0] ea,
                         input logic [31:0] ei, input logic [63:0] ep,
                         input logic ec, input logic ev);
    chk({tag, ".req"},   {63'h0, imem_req_o}, {63'h0, er});
    chk({tag, ".addr"},  imem_addr_o, ea);
    chk({tag, ".inst"},  {32'h0, inst_o}, {32'h0, ei});
    chk({tag, ".pc"},    pc_o, ep);
    chk({tag, ".comp"},  {63'h0, is_compressed_o}, {63'h0, ec});
    chk({tag, ".valid"}, {63'h0, valid_o}, {63'h0, ev});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic step(input logic ack, input logic [31:0] rd, input logic fl,
                      input logic [63:0] tg, input logic lu);
    imem_ack_i = ack; imem_rdata_i = rd; branch_flush_i = fl;
    branch_target_i = tg; load_use_i = lu;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // ack rdata flush target lu | req addr inst pc comp valid (state after the edge)
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B,          NOP,          B,          1'b0, 1'b0));
    vq.push_back(mk(1'b1, 32'h0050_0093, 1'b0, 64'h0,        1'b0, 1'b0, B,          NOP,          B,          1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h4,  32'h0050_0093, B,         1'b0, 1'b1));
    vq.push_back(mk(1'b1, 32'h0001_0001, 1'b0, 64'h0,        1'b0, 1'b0, B + 64'h4,  NOP,          B,          1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h8,  32'h0000_0001, B + 64'h4, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 32'h0093_4501, 1'b0, 64'h0,        1'b0, 1'b0, B + 64'h8,  32'h0000_0001, B + 64'h6, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'hC,  32'h0000_4501, B + 64'h8, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'hC,  NOP,          B + 64'h8,  1'b0, 1'b0));
    vq.push_back(mk(1'b1, 32'hABCD_0050, 1'b0, 64'h0,        1'b0, 1'b0, B + 64'hC,  NOP,          B + 64'h8,  1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b0, B + 64'hC,  32'h0050_0093, B + 64'hA, 1'b0, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h10, 32'h0000_ABCD, B + 64'hE, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 32'h0002_0001, 1'b0, 64'h0,        1'b0, 1'b0, B + 64'h10, NOP,          B + 64'hE,  1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h14, 32'h0000_0001, B + 64'h10, 1'b1, 1'b1));
    vq.push_back(mk(1'b1, 32'h0008_0004, 1'b0, 64'h0,        1'b1, 1'b0, B + 64'h14, 32'h0000_0001, B + 64'h10, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b1, 1'b0, B + 64'h14, 32'h0000_0001, B + 64'h10, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b0, B + 64'h14, 32'h0000_0002, B + 64'h12, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h18, 32'h0000_0004, B + 64'h14, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b1, B + 64'h102,  1'b0, 1'b1, B + 64'h18, NOP,          B + 64'h14, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h18, NOP,          B + 64'h14, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h18, NOP,          B + 64'h14, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0,        1'b0, 1'b0, B + 64'h18, NOP,          B + 64'h14, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h100, NOP,         B + 64'h14, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 32'h4505_0093, 1'b0, 64'h0,        1'b0, 1'b0, B + 64'h100, NOP,         B + 64'h14, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h104, 32'h0000_4505, B + 64'h102, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 32'h0,         1'b0, 64'h0,        1'b0, 1'b1, B + 64'h104, NOP,         B + 64'h102, 1'b0, 1'b0));

    // Reset values
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk_out("reset", 1'b0, B, NOP, B, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].ack, vq[i].rdata, vq[i].flush, vq[i].tgt, vq[i].lu);
      chk_out($sformatf("vec%0d", i + 1), vq[i].e_req, vq[i].e_addr, vq[i].e_inst,
              vq[i].e_pc, vq[i].e_comp, vq[i].e_valid);
    end

    // Flush with a same-cycle ack: data dropped, no drain
    step(1'b1, 32'h1234_5678, 1'b1, 64'h9000_0010, 1'b0);
    chk_out("flush_ack", 1'b0, B + 64'h104, NOP, B + 64'h102, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    chk_out("flush_ack_req", 1'b1, 64'h9000_0010, NOP, B + 64'h102, 1'b0, 1'b0);
    // Two flushes while draining: last target wins, one drain
    step(1'b0, 32'h0, 1'b1, 64'h9000_0020, 1'b0);
    chk_out("drain1", 1'b1, 64'h9000_0010, NOP, B + 64'h102, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 64'h9000_0047, 1'b0);
    chk_out("drain2", 1'b1, 64'h9000_0010, NOP, B + 64'h102, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b0);
    chk_out("drain_ack", 1'b0, 64'h9000_0010, NOP, B + 64'h102, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    chk_out("retarget", 1'b1, 64'h9000_0044, NOP, B + 64'h102, 1'b0, 1'b0);
    step(1'b1, 32'h0001_7777, 1'b0, 64'h0, 1'b0);
    chk_out("retarget_ack", 1'b0, 64'h9000_0044, NOP, B + 64'h102, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    chk_out("retarget_inst", 1'b1, 64'h9000_0048, 32'h0000_0001, 64'h9000_0046, 1'b1, 1'b1);

    // Reset asserted mid-cycle while draining
    step(1'b0, 32'h0, 1'b1, 64'h9000_0200, 1'b0);
    chk_out("pre_reset_drain", 1'b1, 64'h9000_0048, NOP, 64'h9000_0046, 1'b0, 1'b0);
    imem_ack_i = 1'b0; branch_flush_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, B, NOP, B, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0093, 1'b0, 64'h0, 1'b0);
    chk_out("in_reset", 1'b0, B, NOP, B, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 32'h0050_0093, 1'b0, 64'h0, 1'b0);
    chk_out("late_ack", 1'b1, B, NOP, B, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0001, 1'b0, 64'h0, 1'b0);
    chk_out("restart_ack", 1'b0, B, NOP, B, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    chk_out("rvc0", 1'b1, B + 64'h4, 32'h0000_0001, B, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    chk_out("rvc1", 1'b1, B + 64'h4, 32'h0000_0001, B + 64'h2, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
